// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: side-result entries and
// starvation FSM states.
package wb_arb_types;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    logic [4:0] rd;
    rv32i_word  data;
  } side_entry_t;

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    STARVED = 1'b1
  } arb_state_t;

  localparam int unsigned FIFO_DEPTH_DEF   = 2;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the WB stage / side unit / hazard unit (master) and the
// write-port arbiter (slave).
interface wb_port_arbiter_if;
  import wb_arb_types::*;

  logic        pipe_we;
  logic [4:0]  pipe_rd;
  rv32i_word   pipe_wdata;
  logic        side_valid;
  logic        side_ready;
  logic [4:0]  side_rd;
  rv32i_word   side_wdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  rv32i_word   rf_wdata;
  logic        grant_side;
  logic        stall_req;
  logic [31:0] pending_mask;

  modport slave (
    input  pipe_we, pipe_rd, pipe_wdata, side_valid, side_rd, side_wdata,
    output side_ready, rf_we, rf_rd, rf_wdata, grant_side, stall_req, pending_mask
  );

  modport master (
    output pipe_we, pipe_rd, pipe_wdata, side_valid, side_rd, side_wdata,
    input  side_ready, rf_we, rf_rd, rf_wdata, grant_side, stall_req, pending_mask
  );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Side-result buffer: circular FIFO with occupancy count and a decoded mask of
// destination registers held by valid entries.
module wb_result_fifo
  import wb_arb_types::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  side_entry_t i_entry,
  input  logic        i_pop,
  output side_entry_t o_head,
  output logic        o_full,
  output logic        o_empty,
  output logic [31:0] o_pending_mask
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  side_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_off;
  logic [31:0]   w_mask;

  // Pointers are exactly PW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_entry;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (i_pop) r_rptr <= r_rptr + PW'(1);
      if (i_push && !i_pop) r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    w_mask = '0;
    w_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_rptr;
      if ({1'b0, w_off} < r_count) w_mask = w_mask | rd_onehot(r_mem[i].rd);
    end
  end

  assign o_head         = r_mem[r_rptr];
  assign o_full         = (r_count == CW'(DEPTH));
  assign o_empty        = (r_count == '0);
  assign o_pending_mask = w_mask;

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: the pipeline writeback always wins, buffered
// side results retire into WB bubbles, and a starvation FSM requests bubbles.
module wb_port_arbiter
  import wb_arb_types::*;
#(
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic               i_clk,
  input logic               i_rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_nxt;

  logic        w_pipe_wins;
  logic        w_grant;
  logic        w_accept;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  side_entry_t w_head;
  side_entry_t w_side_entry;
  logic [31:0] w_mask;
  logic        w_rf_we;
  logic [4:0]  w_rf_rd;
  rv32i_word   w_rf_wdata;

  // A pipeline write to x0 is not a write, so it leaves the slot to the FIFO.
  assign w_pipe_wins  = bus.pipe_we && (bus.pipe_rd != 5'd0);
  assign w_grant      = !i_rst && !w_pipe_wins && !w_empty;
  assign w_accept     = bus.side_valid && !w_full;
  assign w_push       = w_accept && (bus.side_rd != 5'd0);
  assign w_side_entry = '{rd: bus.side_rd, data: bus.side_wdata};

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_push         (w_push),
    .i_entry        (w_side_entry),
    .i_pop          (w_grant),
    .o_head         (w_head),
    .o_full         (w_full),
    .o_empty        (w_empty),
    .o_pending_mask (w_mask)
  );

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_rd    = '0;
    w_rf_wdata = '0;
    if (!i_rst && w_pipe_wins) begin
      w_rf_we    = 1'b1;
      w_rf_rd    = bus.pipe_rd;
      w_rf_wdata = bus.pipe_wdata;
    end else if (w_grant) begin
      w_rf_we    = 1'b1;
      w_rf_rd    = w_head.rd;
      w_rf_wdata = w_head.data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= NORMAL;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // A full FIFO with the side unit still waiting starves immediately.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      NORMAL: begin
        if (w_grant || w_empty) begin
          w_starve_nxt = '0;
        end else if ((w_full && bus.side_valid) ||
                     (r_starve_cnt == SW'(STARVE_LIMIT - 1))) begin
          w_state_nxt  = STARVED;
          w_starve_nxt = '0;
        end else begin
          w_starve_nxt = r_starve_cnt + SW'(1);
        end
      end
      STARVED: begin
        if (w_grant) begin
          w_state_nxt  = NORMAL;
          w_starve_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = NORMAL;
        w_starve_nxt = '0;
      end
    endcase
  end

  assign bus.side_ready   = !w_full;
  assign bus.rf_we        = w_rf_we;
  assign bus.rf_rd        = w_rf_rd;
  assign bus.rf_wdata     = w_rf_wdata;
  assign bus.grant_side   = w_grant;
  assign bus.stall_req    = (r_state == STARVED);
  assign bus.pending_mask = w_mask;

  // The hazard unit must keep pipeline writes off registers still owed by the side unit.
  a_no_waw: assert property (@(posedge i_clk) disable iff (i_rst)
    !(bus.pipe_we && w_mask[bus.pipe_rd]));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-level reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_wb_port_arbiter;
  import wb_arb_types::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue, starvation is a wait counter plus a flag.
  side_entry_t q[$];
  int          m_starve  = 0;
  bit          m_starved = 0;
  bit          m_pw, m_eg, m_acc;
  int          m_n;
  logic [31:0] m_mask;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_starve  = 0;
      m_starved = 0;
      chk("m_rst_rf_we", bus.rf_we, 0);
      chk("m_rst_grant", bus.grant_side, 0);
      chk("m_rst_stall", bus.stall_req, 0);
      chk("m_rst_mask", bus.pending_mask, 0);
      chk("m_rst_ready", bus.side_ready, 1);
    end else begin
      m_n    = q.size();
      m_pw   = bus.pipe_we && (bus.pipe_rd != 0);
      m_eg   = !m_pw && (m_n > 0);
      m_mask = 0;
      foreach (q[i]) m_mask[q[i].rd] = 1'b1;
      chk("m_rf_we", bus.rf_we, m_pw || m_eg);
      chk("m_grant", bus.grant_side, m_eg);
      chk("m_stall", bus.stall_req, m_starved);
      chk("m_ready", bus.side_ready, m_n < DEPTH);
      chk("m_mask", bus.pending_mask, m_mask);
      if (m_pw) begin
        chk("m_rf_rd_pipe", bus.rf_rd, bus.pipe_rd);
        chk("m_rf_wdata_pipe", bus.rf_wdata, bus.pipe_wdata);
      end else if (m_eg) begin
        chk("m_rf_rd_side", bus.rf_rd, q[0].rd);
        chk("m_rf_wdata_side", bus.rf_wdata, q[0].data);
      end
      m_acc = bus.side_valid && (m_n < DEPTH);
      if (m_starved) begin
        if (m_eg) begin
          m_starved = 0;
          m_starve  = 0;
        end
      end else if (m_eg || m_n == 0) begin
        m_starve = 0;
      end else if ((m_n == DEPTH && bus.side_valid) || m_starve == LIMIT - 1) begin
        m_starved = 1;
        m_starve  = 0;
      end else begin
        m_starve++;
      end
      if (m_eg) void'(q.pop_front());
      if (m_acc && bus.side_rd != 0) q.push_back('{rd: bus.side_rd, data: bus.side_wdata});
    end
  end

  task automatic set_in(input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                        input bit sv, input logic [4:0] srd, input logic [31:0] sd);
    bus.pipe_we    = pwe;
    bus.pipe_rd    = prd;
    bus.pipe_wdata = pd;
    bus.side_valid = sv;
    bus.side_rd    = srd;
    bus.side_wdata = sd;
  endtask

  task automatic drive(input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input bit sv, input logic [4:0] srd, input logic [31:0] sd);
    @(posedge clk);
    #1;
    set_in(pwe, prd, pd, sv, srd, sd);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t0_rf_we", bus.rf_we, 0);
    chk("t0_ready", bus.side_ready, 1);

    // 1: reset while one entry is buffered and another push is in flight
    drive(1, 3, 32'h33, 1, 9, 32'h99);
    drive(1, 3, 32'h34, 1, 10, 32'hAA);
    chk("t1_mask_pre", bus.pending_mask, 32'h0000_0200);
    rst = 1'b1;
    #1;
    chk("t1_rst_rf_we", bus.rf_we, 0);
    chk("t1_rst_mask", bus.pending_mask, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("t1_rf_we", bus.rf_we, 0);
    chk("t1_mask", bus.pending_mask, 0);
    chk("t1_ready", bus.side_ready, 1);
    chk("t1_stall", bus.stall_req, 0);

    // 2: single side result retires on the next idle WB slot
    drive(0, 0, 0, 1, 5, 32'hDEAD_BEEF);
    chk("t2_rf_we0", bus.rf_we, 0);
    chk("t2_mask0", bus.pending_mask, 0);
    idle();
    chk("t2_rf_we", bus.rf_we, 1);
    chk("t2_rf_rd", bus.rf_rd, 5);
    chk("t2_grant", bus.grant_side, 1);
    chk("t2_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
    chk("t2_mask1", bus.pending_mask, 32'h0000_0020);
    idle();
    chk("t2_mask2", bus.pending_mask, 0);

    // 3: FIFO fills behind a busy pipeline, full + valid starves at once
    drive(1, 3, 32'h300, 1, 7, 32'hA1);
    chk("t3_ready0", bus.side_ready, 1);
    drive(1, 3, 32'h301, 1, 7, 32'hA2);
    chk("t3_ready1", bus.side_ready, 1);
    chk("t3_mask1", bus.pending_mask, 32'h0000_0080);
    drive(1, 3, 32'h302, 1, 7, 32'hA3);
    chk("t3_ready_full", bus.side_ready, 0);
    chk("t3_stall0", bus.stall_req, 0);
    drive(1, 3, 32'h303, 0, 0, 0);
    chk("t3_stall1", bus.stall_req, 1);
    chk("t3_pipe_wins", bus.rf_rd, 3);
    chk("t3_no_grant", bus.grant_side, 0);
    idle();
    chk("t3_stall_bubble", bus.stall_req, 1);
    chk("t3_pop1", bus.rf_wdata, 32'hA1);
    drive(1, 3, 32'h304, 0, 0, 0);
    chk("t3_stall_clr", bus.stall_req, 0);
    chk("t3_mask_held", bus.pending_mask, 32'h0000_0080);
    idle();
    chk("t3_pop2", bus.rf_wdata, 32'hA2);
    idle();
    chk("t3_mask_clr", bus.pending_mask, 0);

    // 4: one entry starved by four pipeline writes
    drive(0, 0, 0, 1, 12, 32'hC0C0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 4, 32'h400 + i, 0, 0, 0);
      chk("t4_no_stall", bus.stall_req, 0);
    end
    drive(1, 4, 32'h404, 0, 0, 0);
    chk("t4_stall", bus.stall_req, 1);
    chk("t4_pipe_rd", bus.rf_rd, 4);
    idle();
    chk("t4_stall_bubble", bus.stall_req, 1);
    chk("t4_grant", bus.grant_side, 1);
    chk("t4_rf_rd", bus.rf_rd, 12);
    chk("t4_wdata", bus.rf_wdata, 32'hC0C0);
    idle();
    chk("t4_stall_clr", bus.stall_req, 0);
    chk("t4_mask_clr", bus.pending_mask, 0);

    // 5: simultaneous push and pop at count 1, pointers wrap several times
    drive(1, 3, 32'h500, 1, 16, 32'h5000);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 0, 1, 5'(16 + i), 32'h5000 + i);
      chk("t5_grant", bus.grant_side, 1);
      chk("t5_rd", bus.rf_rd, 16 + i - 1);
      chk("t5_data", bus.rf_wdata, 32'h5000 + i - 1);
      chk("t5_ready", bus.side_ready, 1);
      chk("t5_mask", bus.pending_mask, 32'(1) << (16 + i - 1));
    end
    idle();
    chk("t5_last", bus.rf_wdata, 32'h5008);
    idle();
    chk("t5_mask_clr", bus.pending_mask, 0);

    // 6: pipeline x0 write yields the slot; side push to x0 handshakes but stores nothing
    drive(1, 3, 32'h600, 1, 9, 32'h9999);
    drive(1, 0, 32'h601, 1, 0, 32'hF0F0);
    chk("t6_grant", bus.grant_side, 1);
    chk("t6_rd", bus.rf_rd, 9);
    chk("t6_data", bus.rf_wdata, 32'h9999);
    chk("t6_ready", bus.side_ready, 1);
    chk("t6_mask", bus.pending_mask, 32'h0000_0200);
    idle();
    chk("t6_rf_we", bus.rf_we, 0);
    chk("t6_mask_clr", bus.pending_mask, 0);
    drive(0, 0, 0, 1, 0, 32'hF1);
    chk("t6_ready_x0", bus.side_ready, 1);
    idle();
    chk("t6_rf_we_x0", bus.rf_we, 0);
    chk("t6_mask_x0", bus.pending_mask, 0);
    idle();

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
